dsm_sample_scheduler: RTL and testbench

- Sequences audio/test samples into the DSM DAC datapath.
- Buffers incoming samples in a small FIFO and releases one every OSR clocks, replacing the free-running clk_div + ZOH generator pairing.
- Drives the modulator input and its clock enable.
- Handles priming, underrun and shutdown so the modulator never sees torn or undefined data.

---
 rtl/dsm_sample_scheduler.sv | 131 +++++++++++++
 tb/tb_dsm_sample_scheduler.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dsm_sample_scheduler.sv
// Sample scheduler for the DSM DAC: buffers upstream samples in a small FIFO and
// releases one every OSR clocks to the modulator input, with priming, underrun and shutdown.
module dsm_sample_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int OSR        = 100,
  parameter int FIFO_DEPTH = 4,
  parameter int PRIME_LVL  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          s_valid,
  input  logic [DATA_WIDTH-1:0]         s_data,
  output logic                          s_ready,
  output logic [DATA_WIDTH-1:0]         dsm_in,
  output logic                          dsm_en,
  output logic                          sample_strobe,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic [15:0]                   underrun_cnt,
  output logic [1:0]                    state
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(OSR);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRIME    = 2'd1,
    RUN      = 2'd2,
    UNDERRUN = 2'd3
  } state_t;

  state_t                st;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         cnt;
  logic                  full;
  logic                  stopping;
  logic                  cnt_last;
  logic                  push;
  logic                  pop;

  assign state    = st;
  assign underrun = (st == UNDERRUN);
  assign full     = (fifo_level == LW'(FIFO_DEPTH));
  assign stopping = (st != IDLE) && !enable;
  assign s_ready  = rst && !full && !stopping;
  assign push     = s_valid && s_ready;
  assign cnt_last = (cnt == CW'(OSR - 1));

  // Pop decisions look only at the level before this cycle's push.
  always_comb begin
    pop = 1'b0;
    case (st)
      PRIME:         pop = (fifo_level >= LW'(PRIME_LVL));
      RUN, UNDERRUN: pop = cnt_last && (fifo_level != '0);
      default:       pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st            <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_level    <= '0;
      dsm_in        <= '0;
      dsm_en        <= 1'b0;
      sample_strobe <= 1'b0;
      underrun_cnt  <= '0;
      cnt           <= '0;
    end else if (stopping) begin
      // Shutdown mutes and flushes but keeps the underrun history.
      st            <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_level    <= '0;
      dsm_in        <= '0;
      dsm_en        <= 1'b0;
      sample_strobe <= 1'b0;
      cnt           <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        dsm_in <= mem[rd_ptr];
      end
      fifo_level <= fifo_level + LW'(push) - LW'(pop);

      case (st)
        IDLE: begin
          cnt           <= '0;
          sample_strobe <= 1'b0;
          if (enable) st <= PRIME;
        end
        PRIME: begin
          if (pop) begin
            st            <= RUN;
            dsm_en        <= 1'b1;
            cnt           <= '0;
            sample_strobe <= 1'b0;
          end
        end
        RUN, UNDERRUN: begin
          if (cnt_last) begin
            cnt           <= '0;
            sample_strobe <= 1'b0;
            if (pop) begin
              st <= RUN;
            end else begin
              st <= UNDERRUN;
              if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
            end
          end else begin
            cnt           <= cnt + CW'(1);
            sample_strobe <= (cnt == CW'(OSR - 2));
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsm_sample_scheduler.sv
// Scoreboard bench for dsm_sample_scheduler: a queue-based reference model predicts
// each cycle's outputs, a monitor compares them against the DUT after every edge.
module tb_dsm_sample_scheduler;

  localparam int DW    = 16;
  localparam int OSR   = 4;
  localparam int DEPTH = 4;
  localparam int PLVL  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic [DW-1:0] dsm_in;
  logic          dsm_en;
  logic          sample_strobe;
  logic [2:0]    fifo_level;
  logic          underrun;
  logic [15:0]   underrun_cnt;
  logic [1:0]    state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dsm_sample_scheduler #(
    .DATA_WIDTH(DW), .OSR(OSR), .FIFO_DEPTH(DEPTH), .PRIME_LVL(PLVL)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .dsm_in(dsm_in), .dsm_en(dsm_en), .sample_strobe(sample_strobe),
    .fifo_level(fifo_level), .underrun(underrun), .underrun_cnt(underrun_cnt), .state(state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] dsm;
    logic          en;
    logic          strb;
    int            st;
    int            lvl;
    logic          und;
    logic [15:0]   ucnt;
  } rec_t;

  rec_t exp_q[$];

  // Reference model: sample queue, a period counter and a state number.
  logic [DW-1:0] mq[$];
  int            ms    = 0;
  int            mcnt  = 0;
  logic [DW-1:0] mdsm  = '0;
  logic          men   = 1'b0;
  logic [15:0]   mucnt = '0;
  logic          m_rdy;
  logic          m_push;
  int            m_lvl;
  rec_t          m_rec;

  always @(negedge clk) begin
    m_rdy = rst && (mq.size() < DEPTH) && !(ms != 0 && !enable);
    chk("s_ready", 32'(s_ready), 32'(m_rdy));
    if (!rst) begin
      ms = 0; mq.delete(); mdsm = '0; men = 1'b0; mcnt = 0; mucnt = '0;
    end else if (ms != 0 && !enable) begin
      ms = 0; mq.delete(); mdsm = '0; men = 1'b0; mcnt = 0;
    end else begin
      m_lvl  = mq.size();
      m_push = s_valid && m_rdy;
      if (ms == 0) begin
        if (enable) ms = 1;
      end else if (ms == 1) begin
        if (m_lvl >= PLVL) begin
          mdsm = mq.pop_front(); men = 1'b1; mcnt = 0; ms = 2;
        end
      end else begin
        if (mcnt == OSR - 1) begin
          mcnt = 0;
          if (m_lvl > 0) begin
            mdsm = mq.pop_front(); ms = 2;
          end else begin
            ms = 3;
            if (mucnt != 16'hFFFF) mucnt = mucnt + 16'd1;
          end
        end else begin
          mcnt = mcnt + 1;
        end
      end
      if (m_push) mq.push_back(s_data);
    end
    m_rec.dsm  = mdsm;
    m_rec.en   = men;
    m_rec.strb = (ms >= 2) && (mcnt == OSR - 1);
    m_rec.st   = ms;
    m_rec.lvl  = mq.size();
    m_rec.und  = (ms == 3);
    m_rec.ucnt = mucnt;
    exp_q.push_back(m_rec);
  end

  rec_t r;
  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      chk("dsm_in",        32'(dsm_in),        32'(r.dsm));
      chk("dsm_en",        32'(dsm_en),        32'(r.en));
      chk("sample_strobe", 32'(sample_strobe), 32'(r.strb));
      chk("state",         32'(state),         32'(r.st));
      chk("fifo_level",    32'(fifo_level),    32'(r.lvl));
      chk("underrun",      32'(underrun),      32'(r.und));
      chk("underrun_cnt",  32'(underrun_cnt),  32'(r.ucnt));
    end
  end

  task automatic cyc(input logic v, input logic [DW-1:0] d, output logic acc);
    s_valid = v;
    s_data  = d;
    @(negedge clk);
    acc = v && s_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic acc;
    repeat (n) cyc(1'b0, DW'($urandom), acc);
  endtask

  task automatic push(input logic [DW-1:0] d);
    logic acc;
    int   n;
    n = 0;
    do begin
      cyc(1'b1, d, acc);
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: sample %0h not accepted within 50 cycles", d);
    end
    s_valid = 1'b0;
  endtask

  logic acc_d;

  initial begin
    rst     = 1'b0;
    enable  = 1'b0;
    s_valid = 1'b1;
    s_data  = DW'($urandom);
    repeat (3) @(posedge clk);
    #1;
    rst     = 1'b1;
    s_valid = 1'b0;
    idle(2);

    // prime and run
    enable = 1'b1;
    push(16'd100);
    push(-16'sd200);
    push(16'd300);
    push(-16'sd400);
    idle(20);

    // fill while disabled, then release
    enable = 1'b0;
    idle(2);
    for (int i = 0; i < 4; i++) push(DW'($urandom));
    repeat (3) cyc(1'b1, DW'($urandom), acc_d);
    s_valid = 1'b0;
    enable  = 1'b1;
    idle(30);

    // underrun and recovery
    enable = 1'b0;
    idle(1);
    enable = 1'b1;
    push(DW'($urandom));
    push(DW'($urandom));
    idle(20);
    push(16'd7);
    idle(10);

    // shutdown with samples pending
    enable = 1'b0;
    idle(1);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) push(DW'($urandom));
    enable = 1'b0;
    idle(3);

    // random traffic with occasional shutdowns and resets
    for (int i = 0; i < 600; i++) begin
      rst    = ($urandom_range(0, 199) != 0);
      enable = ($urandom_range(0, 79) != 0);
      cyc((i < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 4) == 0),
          DW'($urandom), acc_d);
    end
    rst    = 1'b1;
    enable = 1'b1;
    idle(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
